tisc_wb_arbiter: RTL

// Round-robin WISHBONE arbiter: shares one slave-side bus among 3 masters
// (0 = PCI bridge master, 1 = VIO debug bridge, 2 = I2C controller).

---
 rtl/tisc_wb_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tisc_wb_arbiter.sv
// Round-robin WISHBONE arbiter: three masters share one slave-side bus, with
// the grant locked for a whole CYC burst and a stall timeout that forces err.
module tisc_wb_arbiter #(
    parameter int unsigned ADR_WIDTH = 21,
    parameter int unsigned DAT_WIDTH = 32,
    parameter int unsigned SEL_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [2:0]             m_cyc_i,
    input  logic [2:0]             m_stb_i,
    input  logic [2:0]             m_we_i,
    input  logic [3*ADR_WIDTH-1:0] m_adr_i,
    input  logic [3*DAT_WIDTH-1:0] m_dat_i,
    input  logic [3*SEL_WIDTH-1:0] m_sel_i,
    output logic [DAT_WIDTH-1:0]   m_dat_o,
    output logic [2:0]             m_ack_o,
    output logic [2:0]             m_err_o,
    output logic [2:0]             m_rty_o,
    output logic                   cyc_o,
    output logic                   stb_o,
    output logic                   we_o,
    output logic [ADR_WIDTH-1:0]   adr_o,
    output logic [DAT_WIDTH-1:0]   dat_o,
    output logic [SEL_WIDTH-1:0]   sel_o,
    input  logic [DAT_WIDTH-1:0]   dat_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i,
    output logic [2:0]             grant_o,
    output logic                   timeout_o
);

    localparam int unsigned NUM_M = 3;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       sel_cyc, sel_stb, busy, stall, to_hit;
    logic [1:0] gnt_idx, cand;
    logic [2:0] win;

    // Granted-master view, stall detection and round-robin winner search
    always_comb begin
        sel_cyc = |(m_cyc_i & gnt_q);
        sel_stb = |(m_stb_i & gnt_q);
        busy    = (state_q == S_BUSY);
        stall   = busy & sel_cyc & sel_stb & ~(ack_i | err_i | rty_i);
        to_hit  = stall & (cnt_q == CNT_W'(TIMEOUT));
        gnt_idx = gnt_q[1] ? 2'd1 : (gnt_q[2] ? 2'd2 : 2'd0);
        win     = '0;
        cand    = '0;
        for (int k = 1; k <= 3; k++) begin
            cand = 2'((int'(last_q) + k) % 3);
            if (win == 3'b000 && m_cyc_i[cand]) win = 3'(1) << cand;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            last_q  <= 2'd2;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (win != 3'b000) begin
                    state_d = S_BUSY;
                    gnt_d   = win;
                end
            end
            S_BUSY: begin
                if (!sel_cyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_idx;
                end else if (to_hit) begin
                    state_d = S_DRAIN;
                end else if (stall) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (!sel_cyc) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    last_d  = gnt_idx;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Slave side follows the granted master only while BUSY; DRAIN blocks responses
    always_comb begin
        m_dat_o   = dat_i;
        grant_o   = gnt_q;
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        we_o      = 1'b0;
        adr_o     = '0;
        dat_o     = '0;
        sel_o     = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rty_o   = '0;
        timeout_o = to_hit;
        if (busy) begin
            cyc_o = sel_cyc;
            stb_o = sel_cyc & sel_stb;
            we_o  = |(m_we_i & gnt_q);
            for (int n = 0; n < NUM_M; n++) begin
                adr_o = adr_o | (m_adr_i[n*ADR_WIDTH +: ADR_WIDTH] & {ADR_WIDTH{gnt_q[n]}});
                dat_o = dat_o | (m_dat_i[n*DAT_WIDTH +: DAT_WIDTH] & {DAT_WIDTH{gnt_q[n]}});
                sel_o = sel_o | (m_sel_i[n*SEL_WIDTH +: SEL_WIDTH] & {SEL_WIDTH{gnt_q[n]}});
            end
            m_ack_o = gnt_q & {3{ack_i}};
            m_err_o = gnt_q & {3{err_i | to_hit}};
            m_rty_o = gnt_q & {3{rty_i}};
        end
    end

endmodule
